// File: rtl/encoder_pkg.sv
// Shared types and constants for the rotary-encoder parameter controller.
package encoder_pkg;

    typedef enum logic {
        ST_BROWSE = 1'b0,
        ST_EDIT   = 1'b1
    } state_e;

    localparam logic DIR_CW  = 1'b1;
    localparam logic DIR_CCW = 1'b0;

endpackage

// File: rtl/encoder_param_controller_if.sv
// Raw encoder pins and user-setting outputs of the encoder parameter controller.
interface encoder_param_controller_if #(
    parameter int NUM_PARAMS = 4,
    parameter int WIDTH      = 8
);
    localparam int SEL_W = $clog2(NUM_PARAMS);

    logic                        sw;
    logic                        dt;
    logic                        key;
    logic [SEL_W-1:0]            sel_o;
    logic                        edit_o;
    logic [NUM_PARAMS*WIDTH-1:0] value_o;
    logic                        step_valid_o;
    logic                        step_dir_o;

    modport master (
        output sw, dt, key,
        input  sel_o, edit_o, value_o, step_valid_o, step_dir_o
    );

    modport slave (
        input  sw, dt, key,
        output sel_o, edit_o, value_o, step_valid_o, step_dir_o
    );

endinterface

// File: rtl/encoder_debounce.sv
// Two-flop synchroniser plus stability-count debounce filter for one raw input.
module encoder_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din_i,
    output logic filt_o,
    output logic init_o
);
    localparam int               CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             filt_q, filt_d;
    logic             init_q, init_d;

    always_comb begin
        sync_d = {sync_q[0], din_i};
        cnt_d  = cnt_q;
        filt_d = filt_q;
        init_d = init_q;
        // Before the first qualification the filter just tracks the line; the
        // init flag rises once it has been stable long enough, so no edge is seen.
        if (!init_q) begin
            if (sync_q[1] != filt_q) begin
                filt_d = sync_q[1];
                cnt_d  = '0;
            end else if (cnt_q == LAST) begin
                init_d = 1'b1;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (sync_q[1] != filt_q) begin
            if (cnt_q == LAST) begin
                filt_d = sync_q[1];
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            filt_q <= 1'b0;
            init_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
            init_q <= init_d;
        end
    end

    assign filt_o = filt_q;
    assign init_o = init_q;

endmodule

// File: rtl/encoder_param_controller.sv
// Encoder front end: debounced detents drive a browse/edit FSM over a bank of
// saturating parameter registers.
module encoder_param_controller
    import encoder_pkg::*;
#(
    parameter int NUM_PARAMS      = 4,
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input logic                       clk,
    input logic                       rst_n,
    encoder_param_controller_if.slave bus
);
    localparam int               SEL_W   = $clog2(NUM_PARAMS);
    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(NUM_PARAMS - 1);

    function automatic logic [WIDTH-1:0] sat_step(input logic [WIDTH-1:0] v,
                                                  input logic             dir);
        if (dir == DIR_CW) return (&v) ? v : v + WIDTH'(1);
        else               return (v == '0) ? v : v - WIDTH'(1);
    endfunction

    function automatic logic [SEL_W-1:0] wrap_step(input logic [SEL_W-1:0] s,
                                                   input logic             dir);
        if (dir == DIR_CW) return (s == SEL_MAX) ? '0 : s + SEL_W'(1);
        else               return (s == '0) ? SEL_MAX : s - SEL_W'(1);
    endfunction

    logic sw_filt, sw_init, dt_filt, dt_init, key_filt, key_init;

    encoder_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw_db (
        .clk(clk), .rst_n(rst_n), .din_i(bus.sw), .filt_o(sw_filt), .init_o(sw_init)
    );
    encoder_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dt_db (
        .clk(clk), .rst_n(rst_n), .din_i(bus.dt), .filt_o(dt_filt), .init_o(dt_init)
    );
    encoder_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_db (
        .clk(clk), .rst_n(rst_n), .din_i(bus.key), .filt_o(key_filt), .init_o(key_init)
    );

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [WIDTH-1:0] val_q [NUM_PARAMS];
    logic [WIDTH-1:0] val_d [NUM_PARAMS];
    logic             step_valid_q, step_valid_d;
    logic             step_dir_q, step_dir_d;
    logic             sw_prev_q, sw_prev_d;
    logic             key_prev_q, key_prev_d;

    logic sw_rise, key_rise, dir;

    assign sw_rise  = sw_init && dt_init && sw_filt && !sw_prev_q;
    assign key_rise = key_init && key_filt && !key_prev_q;
    assign dir      = dt_filt ? DIR_CCW : DIR_CW;

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        val_d        = val_q;
        step_valid_d = 1'b0;
        step_dir_d   = step_dir_q;
        sw_prev_d    = sw_filt;
        key_prev_d   = key_filt;
        // A key press in the same cycle as a detent swallows the detent.
        if (key_rise) begin
            state_d = (state_q == ST_BROWSE) ? ST_EDIT : ST_BROWSE;
        end else if (sw_rise) begin
            step_valid_d = 1'b1;
            step_dir_d   = dir;
            if (state_q == ST_BROWSE) sel_d = wrap_step(sel_q, dir);
            else                      val_d[sel_q] = sat_step(val_q[sel_q], dir);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_BROWSE;
            sel_q        <= '0;
            for (int i = 0; i < NUM_PARAMS; i++) val_q[i] <= '0;
            step_valid_q <= 1'b0;
            step_dir_q   <= 1'b0;
            sw_prev_q    <= 1'b0;
            key_prev_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            val_q        <= val_d;
            step_valid_q <= step_valid_d;
            step_dir_q   <= step_dir_d;
            sw_prev_q    <= sw_prev_d;
            key_prev_q   <= key_prev_d;
        end
    end

    assign bus.sel_o        = sel_q;
    assign bus.edit_o       = (state_q == ST_EDIT);
    assign bus.step_valid_o = step_valid_q;
    assign bus.step_dir_o   = step_dir_q;

    for (genvar g = 0; g < NUM_PARAMS; g++) begin : g_pack
        assign bus.value_o[g*WIDTH +: WIDTH] = val_q[g];
    end

endmodule

// File: tb/tb_encoder_param_controller.sv
// Directed bench for encoder_param_controller with a short debounce window.
module tb_encoder_param_controller;

    localparam int NP = 4;
    localparam int W  = 8;
    localparam int DB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int total = 0;
    int bad   = 0;
    int pulses = 0;
    int lat;
    int p0;

    encoder_param_controller_if #(.NUM_PARAMS(NP), .WIDTH(W)) bus ();

    encoder_param_controller #(
        .NUM_PARAMS(NP), .WIDTH(W), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.step_valid_o === 1'b1) pulses++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic detent(input bit cw);
        bus.dt = ~cw;
        tick(8);
        bus.sw = 1'b1;
        tick(8);
        bus.sw = 1'b0;
        tick(8);
    endtask

    task automatic press();
        bus.key = 1'b1;
        tick(8);
        bus.key = 1'b0;
        tick(8);
    endtask

    function automatic logic [7:0] fld(input int i);
        return bus.value_o[i*W +: W];
    endfunction

    initial begin
        // 1: reset with idle-high sensor lines
        bus.sw = 1'b1; bus.dt = 1'b1; bus.key = 1'b0;
        tick(3);
        chk("rst_sel",   32'(bus.sel_o), 32'd0);
        chk("rst_edit",  32'(bus.edit_o), 32'd0);
        chk("rst_value", bus.value_o, 32'd0);
        rst_n = 1'b1;
        tick(20);
        chk("idle_sel",   32'(bus.sel_o), 32'd0);
        chk("idle_edit",  32'(bus.edit_o), 32'd0);
        chk("idle_value", bus.value_o, 32'd0);
        chk("idle_dir",   32'(bus.step_dir_o), 32'd0);
        chk("idle_pulses", pulses, 0);
        bus.sw = 1'b0;
        tick(10);
        chk("sw_fall_ignored", pulses, 0);

        // 2: browse with wrap in both directions
        detent(1'b1); chk("cw1_sel", 32'(bus.sel_o), 32'd1);
        chk("cw1_dir", 32'(bus.step_dir_o), 32'd1);
        detent(1'b1); chk("cw2_sel", 32'(bus.sel_o), 32'd2);
        detent(1'b1); chk("cw3_sel", 32'(bus.sel_o), 32'd3);
        detent(1'b1); chk("cw_wrap_sel", 32'(bus.sel_o), 32'd0);
        detent(1'b0); chk("ccw_wrap_sel", 32'(bus.sel_o), 32'd3);
        chk("ccw_dir", 32'(bus.step_dir_o), 32'd0);
        chk("browse_pulses", pulses, 5);
        chk("browse_value", bus.value_o, 32'd0);

        // 3: edit index 2 and saturate at both ends
        detent(1'b0); chk("sel2", 32'(bus.sel_o), 32'd2);
        press();
        chk("edit_on", 32'(bus.edit_o), 32'd1);
        p0 = pulses;
        detent(1'b0); detent(1'b0);
        chk("sat_low_val", 32'(fld(2)), 32'd0);
        chk("sat_low_pulses", pulses - p0, 2);
        chk("sat_low_dir", 32'(bus.step_dir_o), 32'd0);
        p0 = pulses;
        detent(1'b1);
        chk("edit_first_cw", 32'(fld(2)), 32'd1);
        for (int i = 1; i < 260; i++) detent(1'b1);
        chk("sat_high_val", 32'(fld(2)), 32'd255);
        chk("sat_high_pulses", pulses - p0, 260);
        chk("others_zero", bus.value_o & ~32'h00FF_0000, 32'd0);
        chk("edit_sel_frozen", 32'(bus.sel_o), 32'd2);
        press();
        chk("edit_off", 32'(bus.edit_o), 32'd0);

        // 4: debounce glitch rejection and latency
        p0 = pulses;
        bus.sw = 1'b1;
        tick(3);
        bus.sw = 1'b0;
        tick(15);
        chk("glitch_pulses", pulses - p0, 0);
        chk("glitch_sel", 32'(bus.sel_o), 32'd2);
        lat = -1;
        bus.sw = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick(1);
            if (bus.step_valid_o === 1'b1 && lat < 0) lat = c;
        end
        bus.sw = 1'b0;
        tick(10);
        chk("step_latency", lat, 7);
        chk("stable_pulses", pulses - p0, 1);
        chk("stable_sel", 32'(bus.sel_o), 32'd3);

        // 5: key and detent land in the same cycle
        p0 = pulses;
        bus.sw = 1'b1; bus.key = 1'b1;
        tick(10);
        bus.sw = 1'b0; bus.key = 1'b0;
        tick(10);
        chk("sim_edit", 32'(bus.edit_o), 32'd1);
        chk("sim_sel", 32'(bus.sel_o), 32'd3);
        chk("sim_pulses", pulses - p0, 0);

        // 6: asynchronous reset in the middle of editing
        press();
        detent(1'b0); detent(1'b0);
        chk("sel1", 32'(bus.sel_o), 32'd1);
        press();
        for (int i = 0; i < 5; i++) detent(1'b1);
        chk("val1_five", 32'(fld(1)), 32'd5);
        chk("val1_edit", 32'(bus.edit_o), 32'd1);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_edit", 32'(bus.edit_o), 32'd0);
        chk("mid_rst_sel",  32'(bus.sel_o), 32'd0);
        chk("mid_rst_val1", 32'(fld(1)), 32'd0);
        chk("mid_rst_value", bus.value_o, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(12);
        chk("post_rst_value", bus.value_o, 32'd0);
        chk("post_rst_edit", 32'(bus.edit_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/encoder_param_controller.md
# encoder_param_controller

Sequencing controller for the rotary-encoder front end. It synchronises and debounces the two quadrature sensor lines and the encoder push-button, then decodes each detent into a signed step. Steps are routed to one of `NUM_PARAMS` saturating parameter registers through a two-state browse/edit FSM. The block sits between the raw encoder pins and any consumer of user-adjustable settings, and replaces free-running rotation counting.

## Interface

Parameters:
- `NUM_PARAMS`, 4, number of parameter registers (2..16).
- `WIDTH`, 8, bits per parameter register.
- `DEBOUNCE_CYCLES`, 1000, consecutive stable clk cycles required before a filtered input changes (≥2).

Ports:
- `clk`  in  1  single system clock; all logic on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sw`  in  1  sensor A output, asynchronous to clk.
- `dt`  in  1  sensor B output, asynchronous to clk.
- `key`  in  1  push-button, active-high, asynchronous.
- `sel_o`  out  $clog2(NUM_PARAMS)  index of the currently selected parameter.
- `edit_o`  out  1  1 = EDIT state, 0 = BROWSE state.
- `value_o`  out  NUM_PARAMS*WIDTH  packed parameter registers; parameter i is at [i*WIDTH +: WIDTH].
- `step_valid_o`  out  1  one-cycle pulse per accepted detent.
- `step_dir_o`  out  1  direction of the last accepted step; 1 = CW (+1), 0 = CCW (−1).

## Operation

Input conditioning, per input (`sw`, `dt`, `key`):
- 2-flop synchroniser, then debounce filter.
- The filtered value takes the synchronised value only after it has differed from the filtered value for `DEBOUNCE_CYCLES` consecutive cycles.
- Any return to the old value resets the stability count, so glitches shorter than `DEBOUNCE_CYCLES` are rejected.
- After reset, the first filter qualification loads the filter without producing an edge. An idle-high line at reset therefore yields no spurious event.

Step decode:
- Trigger: rising edge of filtered `sw`.
- Filtered `dt` = 0 gives CW (+1); filtered `dt` = 1 gives CCW (−1).
- Falling edges of `sw` and all `dt` edges are ignored.

Key event:
- Trigger: rising edge of filtered `key` only. Release does nothing.

FSM, states BROWSE and EDIT (reset state BROWSE):
- BROWSE + step: `sel_o` moves ±1 modulo `NUM_PARAMS`. `NUM_PARAMS−1` +1 wraps to 0; 0 −1 wraps to `NUM_PARAMS−1`.
- BROWSE + key: go to EDIT; `sel_o` is frozen.
- EDIT + step: the selected register moves ±1 and saturates at 0 and 2^WIDTH−1 (no wrap).
- EDIT + key: go to BROWSE.
- Key and step in the same cycle: the key event wins and the step is discarded. `step_valid_o` stays 0 that cycle.

Other rules:
- `step_valid_o`/`step_dir_o` report every accepted step in both states, including saturated steps that leave the value unchanged.
- Parameter registers not selected never change.

## Timing

- Reset values: `sel_o`=0, `edit_o`=0, all `value_o` fields=0, `step_valid_o`=0, `step_dir_o`=0, filters=0, stability counters=0, init flags cleared.
- Reset asserted mid-operation clears everything immediately (asynchronous). Any partial debounce count is lost.
- Raw input stable change to filtered change: 2 + `DEBOUNCE_CYCLES` cycles.
- Filtered `sw` rising edge at cycle t: `step_valid_o`=1 at t+1, and `sel_o`/`value_o` updated in that same cycle t+1.
- Filtered `key` rising edge at cycle t: `edit_o` toggles at t+1.
- Minimum spacing between accepted steps is set by the debounce filter: one step per `sw` period ≥ 2·`DEBOUNCE_CYCLES`.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure

- Shared package `encoder_pkg`:
  - state encoding `ST_BROWSE`=1'b0, `ST_EDIT`=1'b1;
  - direction constants `DIR_CW`=1'b1, `DIR_CCW`=1'b0.
- Sub-module `encoder_debounce`: synchroniser, stability counter, init flag and registered filtered output, parameterised by `DEBOUNCE_CYCLES`. It is instantiated three times.
- Top level contains edge detection, step decode, FSM and the parameter register array.

## Test plan

All scenarios use `DEBOUNCE_CYCLES`=4, `NUM_PARAMS`=4, `WIDTH`=8.

1. Reset: hold `rst_n`=0 with `sw`=1 and `dt`=1, then release and idle for 20 cycles. Required: all outputs 0 and no `step_valid_o` pulse.
2. Browse wrap:
   - Three CW detents (`dt`=0 at each `sw` rise) give `sel_o` 1, 2, 3.
   - A fourth CW detent gives `sel_o`=0.
   - One CCW detent then gives `sel_o`=3.
3. Edit saturation: select index 2, press `key` (`edit_o`→1), apply 2 CCW detents. Required:
   - `value_o[2]` stays 0;
   - two `step_valid_o` pulses with `step_dir_o`=0;
   - 260 CW detents leave `value_o[2]` at 255;
   - all other fields stay 0.
4. Debounce: 3-cycle `sw` glitch high gives no step. A 10-cycle stable `sw` high gives exactly one step, with `step_valid_o` exactly 7 cycles after the raw rise.
5. Simultaneous events: align filtered `key` and `sw` rising edges in the same cycle while in BROWSE. Required: `edit_o`→1, `sel_o` unchanged, no `step_valid_o`.
6. Mid-operation reset: in EDIT with `value_o[1]`=5, pulse `rst_n` low for 1 cycle. Required: `edit_o`=0, `sel_o`=0, `value_o[1]`=0 immediately.
